hamming_window_ctrl: RTL and testbench
======================================

# hamming_window_ctrl

- Sequences one Hamming-window frame of `WIN_LEN` signed 16-bit samples through the shared 14-bit-unsigned × 16-bit-signed, 30-bit-product combinational multiplier.
- Fetches coefficients from the 1-cycle-latency window coefficient ROM and streams windowed samples out over a valid/ready interface.
- Controlled by the standard ap_start/ap_done/ap_idle/ap_ready block-level handshake.
- Sits between the sample input stream and the FFT front end.

## Interface
- `WIN_LEN`, 1024, samples per frame (≥2).
- `ADDR_W`, 10, ROM address width (2^ADDR_W ≥ WIN_LEN).
- `FRAC_BITS`, 13, coefficient fractional bits (unsigned Q1.13; 1.0 = 8192).
- `ap_clk`  in  1  single clock, rising edge.
- `ap_rst_n`  in  1  reset, asynchronous, active-low.
- `ap_start`  in  1  begin frame (sampled in IDLE only).
- `ap_done`  out  1  one-cycle pulse, frame complete.
- `ap_idle`  out  1  high in IDLE.
- `ap_ready`  out  1  one-cycle pulse, coincident with ap_done.
- `in_data`  in  16  signed sample.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  controller accepts sample.
- `out_data`  out  16  signed windowed sample.
- `out_valid`  out  1  output valid.
- `out_ready`  in  1  downstream accepts.
- `coef_addr`  out  ADDR_W  ROM address.
- `coef_ce`  out  1  ROM read enable; `coef_q` is updated the cycle after ce. The ROM holds `coef_q` while ce is low.
- `coef_q`  in  14  ROM data.
- `mul_a`  out  14  multiplier unsigned operand; equals `coef_q`.
- `mul_b`  out  16  multiplier signed operand; equals `in_data`.
- `mul_p`  in  30  signed product (combinational).

## Operation
- **FSM states:** IDLE, PREFETCH, RUN, DRAIN, DONE.
- **IDLE:** `ap_idle`=1. On `ap_start`=1:
  - assert `coef_ce`=1 with `coef_addr`=0;
  - clear `idx`;
  - go to PREFETCH.
- **PREFETCH:** one cycle; `coef_q` becomes coef[0]. Go to RUN.
- **RUN:**
  - `in_ready` = (`out_valid`==0) || `out_ready`.
  - A sample is accepted when `in_valid` && `in_ready`.
  - On accept:
    - register `out_data` ← result(`mul_p`);
    - set `out_valid`=1;
    - if `idx` < WIN_LEN-1: pulse `coef_ce` with `coef_addr`=`idx`+1 and increment `idx`;
    - else (`idx` == WIN_LEN-1): no ROM read; go to DRAIN.
  - When there is no accept but `out_ready` is high, `out_valid` clears.
- **DRAIN:** `in_ready`=0. Wait until `out_valid`==0 or (`out_valid` && `out_ready`), then go to DONE.
- **DONE:** `ap_done`=`ap_ready`=1 for one cycle, then go to IDLE.
- **Arithmetic:**
  - result = `mul_p` >>> FRAC_BITS (arithmetic shift), truncated to 16 bits.
  - Because the coefficient is ≤ 8192, |result| ≤ |`in_data`|, so no saturation is required.
- **`ap_start` handling:** ignored outside IDLE. If `ap_start` is held high in DONE, the next frame starts on the following IDLE cycle.
- **Reset (asynchronous, any state, mid-frame included):**
  - FSM → IDLE, `idx`=0, remaining frame discarded.
  - Reset values: `ap_idle`=1; `ap_done`, `ap_ready`, `in_ready`, `out_valid`, `coef_ce`=0; `out_data`, `coef_addr`=0.

## Timing
- Throughput: one sample per cycle in RUN when `in_valid` and `out_ready` are held high.
- Latency: accept at edge N → `out_valid`/`out_data` visible after edge N, consumed at edge N+1 or later.
- `ap_start` → first possible accept: 2 cycles (IDLE → PREFETCH → RUN).
- Frame at full rate: `ap_done` occurs WIN_LEN+3 cycles after the `ap_start` edge.
- `mul_a`/`mul_b` are combinational pass-throughs. The registered path is `coef_q`/`in_data` → `mul_p` → `out_data`.
- Backpressure:
  - while `out_valid`=1 and `out_ready`=0, `in_ready`=0;
  - `out_data` holds stable;
  - no ROM read is issued.

## Configuration
- Macro: `HAMMING_WINDOW_CTRL_ROUND_EN`.
- **Defined:** result = (`mul_p` + 2^(FRAC_BITS-1)) >>> FRAC_BITS. This is round-half-up, computed on a 31-bit intermediate. The limits still fit 16 bits: 32767·8192+4096 → 32767, −32768·8192+4096 → −32768.
- **Undefined:** plain arithmetic shift (truncation toward −∞).

## Test plan
- **Reset values:** hold `ap_rst_n`=0 → `ap_idle`=1, all other outputs 0. Assert reset mid-RUN at `idx`=5 → next cycle IDLE, `out_valid`=0, and no `ap_done`.
- **Full-rate frame:**
  - stimulus: WIN_LEN=8, ROM all 8192, inputs 1..8 with `in_valid`/`out_ready` held high;
  - required: outputs 1..8 on consecutive cycles, and `ap_done` pulses exactly once, 11 cycles after start.
- **Truncation and rounding:**
  - stimulus: coef 4096 (0.5), `in_data`=−3;
  - required: −2 without the macro, −1 with it;
  - also: `in_data`=−32768, coef 8192 → −32768.
- **Backpressure:** `out_ready`=0 for 4 cycles mid-frame → `in_ready`=0, `out_data` stable, `coef_ce`=0. On release, the sequence resumes with no loss or duplication.
- **Sparse input:** `in_valid` toggles every other cycle → coefficient/sample pairing is exact. `coef_addr` sequence is 0..WIN_LEN-1 with no read past the last address.
- **Restart:** `ap_start` held high → back-to-back frames each start with coef[0]. `ap_start` pulsed during RUN → ignored.

Source files
------------

// File: rtl/hamming_window_ctrl.sv
// hamming_window_ctrl
//   Streams one frame of WIN_LEN signed 16-bit samples through an external
//   14u x 16s combinational multiplier. Window coefficients come from a
//   1-cycle-latency ROM. Frames are started and finished with the
//   ap_start/ap_done/ap_idle/ap_ready block handshake.
//
// Ports
//   ap_clk, ap_rst_n            clock, async active-low reset
//   ap_start/done/idle/ready    block-level handshake
//   in_data/in_valid/in_ready   sample input stream
//   out_data/out_valid/out_ready windowed sample output stream
//   coef_addr/coef_ce/coef_q    window coefficient ROM port
//   mul_a/mul_b/mul_p           shared multiplier port
//
// Build option
//   HAMMING_WINDOW_CTRL_ROUND_EN : round-half-up instead of truncating the
//                                  scaled product.
module hamming_window_ctrl #(
  parameter int unsigned WIN_LEN   = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned FRAC_BITS = 13
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              coef_ce,
  input  logic [13:0]       coef_q,
  output logic [13:0]       mul_a,
  output logic [15:0]       mul_b,
  input  logic [29:0]       mul_p
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              last_idx;
  logic [30:0]       prod_ext;
  logic [15:0]       result_c;
  logic              unused_prod;

  // Multiplier operands are plain pass-throughs; the product comes back combinationally.
  assign mul_a = coef_q;
  assign mul_b = in_data;

  // Scale the Q1.13 product back to sample units (sign-extended to 31 bits).
`ifdef HAMMING_WINDOW_CTRL_ROUND_EN
  localparam logic [30:0] HALF_LSB = 31'(1) << (FRAC_BITS - 1);
  always_comb prod_ext = {mul_p[29], mul_p} + HALF_LSB;
`else
  always_comb prod_ext = {mul_p[29], mul_p};
`endif

  assign result_c    = prod_ext[FRAC_BITS +: 16];
  assign unused_prod = ^{prod_ext[30:FRAC_BITS+16], prod_ext[FRAC_BITS-1:0]};

  // Input is accepted only in RUN, and only when the output slot is free or draining.
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_idx = (idx_q == ADDR_W'(WIN_LEN - 1));

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (ap_start) state_d = S_PREFETCH;
      S_PREFETCH: state_d = S_RUN;
      S_RUN:      if (accept && last_idx) state_d = S_DRAIN;
      S_DRAIN:    if (!out_valid_q || out_ready) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath next values.
  always_comb begin
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    coef_ce     = 1'b0;
    coef_addr   = '0;
    ap_idle     = 1'b0;
    ap_done     = 1'b0;
    ap_ready    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ap_idle     = 1'b1;
        out_valid_d = 1'b0;
        if (ap_start) begin
          coef_ce = 1'b1;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          out_data_d  = result_c;
          out_valid_d = 1'b1;
          // Fetch the next coefficient so it lands in coef_q for the next accept.
          if (!last_idx) begin
            coef_ce   = 1'b1;
            coef_addr = idx_q + ADDR_W'(1);
            idx_d     = idx_q + ADDR_W'(1);
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      S_DONE: begin
        ap_done     = 1'b1;
        ap_ready    = 1'b1;
        out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hamming_window_ctrl.sv
`timescale 1ns/1ps
module tb_hamming_window_ctrl;

  localparam int W    = 8;
  localparam int AW   = 3;
  localparam int MAXC = 400;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready;
  logic [15:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] coef_addr;
  logic          coef_ce;
  logic [13:0]   coef_q = '0;
  logic [13:0]   mul_a;
  logic [15:0]   mul_b;
  logic [29:0]   mul_p;

  hamming_window_ctrl #(.WIN_LEN(W), .ADDR_W(AW), .FRAC_BITS(13)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_addr(coef_addr), .coef_ce(coef_ce), .coef_q(coef_q),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  always #5 ap_clk = ~ap_clk;

  // Environment: coefficient ROM and multiplier
  logic [13:0] rom  [W];
  logic [15:0] samp [W];

  always @(posedge ap_clk) if (coef_ce) coef_q <= rom[coef_addr];

  logic signed [29:0] a_ext, b_ext;
  assign a_ext = {16'b0, mul_a};
  assign b_ext = {{14{mul_b[15]}}, mul_b};
  assign mul_p = 30'(a_ext * b_ext);

  // Observation logs
  logic [15:0] got_q[$];
  int          addr_q[$];
  int          done_cnt = 0;
  int          stall_cycles, stall_bad;
  int          checks = 0;
  int          passes = 0;

  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (coef_ce) addr_q.push_back(int'(coef_addr));
      if (ap_done) done_cnt++;
    end
  end

  // Reference: sample * coef / 8192, floored (or rounded half-up)
  function automatic logic [15:0] ref_win(input logic signed [15:0] x, input logic [13:0] c);
    longint p;
    p = longint'(x) * longint'(c);
`ifdef HAMMING_WINDOW_CTRL_ROUND_EN
    p = p + 4096;
`endif
    return 16'(p >>> 13);
  endfunction

  task automatic clear_logs();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic randomize_frame();
    for (int k = 0; k < W; k++) begin
      rom[k]  = 14'($urandom_range(0, 8192));
      samp[k] = 16'($urandom());
    end
  endtask

  // Drive one frame. vmode: 0 full, 1 alternate, 2 random in_valid.
  // rmode: 0 out_ready high, 1 random. stall_at>0: out_ready low for 4 cycles.
  task automatic feed_frame(input int vmode, input int rmode, input bit use_pulse,
                            input bit mid_pulse, input int stall_at);
    int i, cyc;
    bit acc, dn, in_stall;
    logic [15:0] held;
    i = 0; cyc = 0; dn = 0; held = '0;
    stall_cycles = 0; stall_bad = 0;
    if (use_pulse) begin
      while (!ap_idle && cyc < MAXC) begin @(posedge ap_clk); #1; cyc++; end
      ap_start = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      cyc = 0;
    end
    while (!(dn && i == W) && cyc < MAXC) begin
      in_valid = (i < W) && ((vmode == 0) || (vmode == 1 && (cyc % 2) == 0) ||
                             (vmode == 2 && $urandom_range(0, 1) == 1));
      in_data  = (i < W) ? samp[i] : 16'h0;
      in_stall = (stall_at > 0) && (cyc >= stall_at) && (cyc < stall_at + 4);
      out_ready = in_stall ? 1'b0 : (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mid_pulse) ap_start = (i == 3);
      @(negedge ap_clk);
      acc = in_valid && in_ready;
      if (ap_done) dn = 1;
      if (in_stall) begin
        if (cyc == stall_at) held = out_data;
        stall_cycles++;
        if (in_ready !== 1'b0 || coef_ce !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
          stall_bad++;
      end
      @(posedge ap_clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (mid_pulse) ap_start = 1'b0;
    checks++;
    if (cyc >= MAXC)
      $display("FAIL frame_timeout: accepted %0d done %0d after %0d cycles, required frame completion", i, dn, cyc);
    else passes++;
  endtask

  task automatic test_reset();
    int i, cyc, nd;
    bit acc;
    ap_rst_n = 1'b0; ap_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++; if (ap_idle !== 1'b1) $display("FAIL rst_ap_idle: got %b want 1", ap_idle); else passes++;
    checks++; if ({ap_done, ap_ready, in_ready, out_valid, coef_ce} !== 5'b0)
      $display("FAIL rst_ctrl_outs: got %b want 00000", {ap_done, ap_ready, in_ready, out_valid, coef_ce}); else passes++;
    checks++; if (out_data !== 16'h0) $display("FAIL rst_out_data: got %h want 0000", out_data); else passes++;
    checks++; if (coef_addr !== '0) $display("FAIL rst_coef_addr: got %0d want 0", coef_addr); else passes++;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    // Reset in the middle of RUN after five accepts (idx = 5)
    randomize_frame();
    clear_logs();
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    i = 0; cyc = 0;
    while (i < 5 && cyc < 50) begin
      in_data = samp[i];
      @(negedge ap_clk);
      acc = in_valid && in_ready;
      @(posedge ap_clk); #1;
      if (acc) i++;
      cyc++;
    end
    checks++; if (i != 5) $display("FAIL midrun_accepts: got %0d want 5", i); else passes++;
    ap_rst_n = 1'b0;
    #2;
    checks++; if (ap_idle !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midrun_rst_async: idle %b valid %b want 1 0", ap_idle, out_valid); else passes++;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1; in_valid = 1'b0;
    nd = 0;
    repeat (6) begin @(negedge ap_clk); if (ap_done) nd++; end
    checks++; if (nd != 0 || ap_idle !== 1'b1)
      $display("FAIL midrun_no_done: done pulses %0d idle %b want 0 1", nd, ap_idle); else passes++;
  endtask

  task automatic test_full_rate();
    int i, first_out, last_out, gaps, n_done, done_cyc;
    bit acc;
    for (int k = 0; k < W; k++) begin rom[k] = 14'd8192; samp[k] = 16'(k + 1); end
    clear_logs();
    i = 0; first_out = -1; last_out = -1; gaps = 0; n_done = 0; done_cyc = -1;
    ap_start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = samp[0];
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    // k numbers the clock period that ends at the k-th edge after the start edge
    for (int k = 1; k <= 20; k++) begin
      in_valid = (i < W);
      in_data  = (i < W) ? samp[i] : 16'h0;
      @(negedge ap_clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (last_out >= 0 && k != last_out + 1) gaps++;
        if (first_out < 0) first_out = k;
        last_out = k;
      end
      if (ap_done) begin n_done++; done_cyc = k; end
      @(posedge ap_clk); #1;
      if (acc) i++;
    end
    in_valid = 1'b0;
    checks++; if (got_q.size() != W) $display("FAIL full_count: got %0d want %0d", got_q.size(), W); else passes++;
    for (int k = 0; k < W; k++) begin
      checks++; if (got_q[k] !== 16'(k + 1)) $display("FAIL full_data[%0d]: got %0d want %0d", k, got_q[k], k + 1); else passes++;
    end
    checks++; if (first_out != 3 || gaps != 0)
      $display("FAIL full_timing: first %0d gaps %0d want 3 0", first_out, gaps); else passes++;
    checks++; if (n_done != 1 || done_cyc != W + 3)
      $display("FAIL full_done: pulses %0d at %0d want 1 at %0d", n_done, done_cyc, W + 3); else passes++;
  endtask

  task automatic test_arith();
    logic [15:0] exp0;
`ifdef HAMMING_WINDOW_CTRL_ROUND_EN
    exp0 = 16'hFFFF;
`else
    exp0 = 16'hFFFE;
`endif
    randomize_frame();
    rom[0] = 14'd4096; samp[0] = 16'hFFFD;
    rom[1] = 14'd8192; samp[1] = 16'h8000;
    rom[2] = 14'd8192; samp[2] = 16'h7FFF;
    clear_logs();
    feed_frame(0, 0, 1'b1, 1'b0, 0);
    checks++; if (got_q.size() != W) $display("FAIL arith_count: got %0d want %0d", got_q.size(), W); else passes++;
    checks++; if (got_q[0] !== exp0) $display("FAIL arith_half_neg3: got %h want %h", got_q[0], exp0); else passes++;
    checks++; if (got_q[1] !== 16'h8000) $display("FAIL arith_min: got %h want 8000", got_q[1]); else passes++;
    checks++; if (got_q[2] !== 16'h7FFF) $display("FAIL arith_max: got %h want 7fff", got_q[2]); else passes++;
    for (int k = 3; k < W; k++) begin
      checks++; if (got_q[k] !== ref_win(samp[k], rom[k]))
        $display("FAIL arith_data[%0d]: got %h want %h", k, got_q[k], ref_win(samp[k], rom[k])); else passes++;
    end
  endtask

  task automatic test_backpressure();
    randomize_frame();
    clear_logs();
    feed_frame(0, 0, 1'b1, 1'b0, 5);
    checks++; if (stall_cycles != 4 || stall_bad != 0)
      $display("FAIL bp_hold: stall cycles %0d bad %0d want 4 0", stall_cycles, stall_bad); else passes++;
    checks++; if (got_q.size() != W || done_cnt != 1)
      $display("FAIL bp_count: outputs %0d done %0d want %0d 1", got_q.size(), done_cnt, W); else passes++;
    for (int k = 0; k < W; k++) begin
      checks++; if (got_q[k] !== ref_win(samp[k], rom[k]))
        $display("FAIL bp_data[%0d]: got %h want %h", k, got_q[k], ref_win(samp[k], rom[k])); else passes++;
    end
  endtask

  task automatic test_sparse();
    randomize_frame();
    clear_logs();
    feed_frame(1, 0, 1'b1, 1'b0, 0);
    checks++; if (addr_q.size() != W) $display("FAIL sparse_reads: got %0d want %0d", addr_q.size(), W); else passes++;
    for (int k = 0; k < W; k++) begin
      checks++; if (addr_q[k] != k) $display("FAIL sparse_addr[%0d]: got %0d want %0d", k, addr_q[k], k); else passes++;
      checks++; if (got_q[k] !== ref_win(samp[k], rom[k]))
        $display("FAIL sparse_data[%0d]: got %h want %h", k, got_q[k], ref_win(samp[k], rom[k])); else passes++;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      randomize_frame();
      clear_logs();
      feed_frame(2, 1, 1'b1, 1'b0, 0);
      checks++; if (got_q.size() != W || done_cnt != 1)
        $display("FAIL rand_count[%0d]: outputs %0d done %0d want %0d 1", f, got_q.size(), done_cnt, W); else passes++;
      for (int k = 0; k < W; k++) begin
        checks++; if (got_q[k] !== ref_win(samp[k], rom[k]))
          $display("FAIL rand_data[%0d][%0d]: got %h want %h", f, k, got_q[k], ref_win(samp[k], rom[k])); else passes++;
      end
    end
  endtask

  task automatic test_restart();
    randomize_frame();
    clear_logs();
    ap_start = 1'b1;
    feed_frame(0, 0, 1'b0, 1'b0, 0);
    feed_frame(0, 0, 1'b0, 1'b0, 0);
    ap_start = 1'b0;
    checks++; if (done_cnt != 2 || got_q.size() != 2 * W || addr_q.size() != 2 * W)
      $display("FAIL b2b_count: done %0d outputs %0d reads %0d want 2 %0d %0d",
               done_cnt, got_q.size(), addr_q.size(), 2 * W, 2 * W); else passes++;
    for (int k = 0; k < 2 * W; k++) begin
      checks++; if (addr_q[k] != k % W || got_q[k] !== ref_win(samp[k % W], rom[k % W]))
        $display("FAIL b2b_item[%0d]: addr %0d data %h want %0d %h", k, addr_q[k], got_q[k],
                 k % W, ref_win(samp[k % W], rom[k % W])); else passes++;
    end
    // ap_start pulsed mid-RUN must be ignored
    randomize_frame();
    clear_logs();
    feed_frame(0, 0, 1'b1, 1'b1, 0);
    repeat (4) @(posedge ap_clk);
    #1;
    checks++; if (done_cnt != 1 || addr_q.size() != W || got_q.size() != W)
      $display("FAIL midstart_ignored: done %0d reads %0d outputs %0d want 1 %0d %0d",
               done_cnt, addr_q.size(), got_q.size(), W, W); else passes++;
    for (int k = 0; k < W; k++) begin
      checks++; if (got_q[k] !== ref_win(samp[k], rom[k]))
        $display("FAIL midstart_data[%0d]: got %h want %h", k, got_q[k], ref_win(samp[k], rom[k])); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_arith();
    test_backpressure();
    test_sparse();
    test_random();
    test_restart();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
